// File: rtl/recirculador_param.sv
// recirculador_param: routes each lane forward or onto the recirculation path, switching only
// at word boundaries; outputs are registered (1-cycle latency) and recirculated words are counted per lane.

module recirculador_lane #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_route,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic              o_fwd_valid,
  output logic [DATA_W-1:0] o_rec_data,
  output logic              o_rec_valid,
  output logic [CNT_W-1:0]  o_count
);
  logic [DATA_W-1:0] r_fwd_data, r_rec_data;
  logic              r_fwd_valid, r_rec_valid;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_data  <= '0;
      r_rec_data  <= '0;
      r_fwd_valid <= 1'b0;
      r_rec_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      // Invalid lanes still carry their data on the active path; the idle path is held at zero.
      r_fwd_valid <= ~i_route & i_valid;
      r_rec_valid <= i_route & i_valid;
      r_fwd_data  <= i_route ? '0 : i_data;
      r_rec_data  <= i_route ? i_data : '0;
      if (i_clr)
        r_count <= '0;
      else if (i_route && i_valid && (r_count != '1))
        r_count <= r_count + 1'b1;
    end
  end

  assign o_fwd_data  = r_fwd_data;
  assign o_fwd_valid = r_fwd_valid;
  assign o_rec_data  = r_rec_data;
  assign o_rec_valid = r_rec_valid;
  assign o_count     = r_count;
endmodule

module recirculador_param #(
  parameter int DATA_W = 8,
  parameter int NLANES = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NLANES*DATA_W-1:0] data_in,
  input  logic [NLANES-1:0]        valid_in,
  input  logic                     selector_idle,
  input  logic                     clr_count,
  output logic [NLANES*DATA_W-1:0] fwd_data,
  output logic [NLANES-1:0]        fwd_valid,
  output logic [NLANES*DATA_W-1:0] rec_data,
  output logic [NLANES-1:0]        rec_valid,
  output logic                     route,
  output logic                     switch_pending,
  output logic [NLANES*CNT_W-1:0]  rec_count
);
  typedef enum logic [1:0] {S_RECIRC, S_FWD, S_PEND_FWD, S_PEND_REC} state_t;

  state_t r_state, w_next;
  logic   w_any_valid;

  assign w_any_valid = |valid_in;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RECIRC;
    else       r_state <= w_next;
  end

  // Pending states hold the old route until a cycle with no valid lane, so a word never splits.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RECIRC:   if (!selector_idle) w_next = w_any_valid ? S_PEND_FWD : S_FWD;
      S_FWD:      if (selector_idle)  w_next = w_any_valid ? S_PEND_REC : S_RECIRC;
      S_PEND_FWD: if (selector_idle)  w_next = S_RECIRC;
                  else if (!w_any_valid) w_next = S_FWD;
      S_PEND_REC: if (!selector_idle) w_next = S_FWD;
                  else if (!w_any_valid) w_next = S_RECIRC;
      default:    w_next = S_RECIRC;
    endcase
  end

  assign route          = (r_state == S_RECIRC) || (r_state == S_PEND_FWD);
  assign switch_pending = (r_state == S_PEND_FWD) || (r_state == S_PEND_REC);

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    recirculador_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .i_route     (route),
      .i_clr       (clr_count),
      .i_data      (data_in[i*DATA_W +: DATA_W]),
      .i_valid     (valid_in[i]),
      .o_fwd_data  (fwd_data[i*DATA_W +: DATA_W]),
      .o_fwd_valid (fwd_valid[i]),
      .o_rec_data  (rec_data[i*DATA_W +: DATA_W]),
      .o_rec_valid (rec_valid[i]),
      .o_count     (rec_count[i*CNT_W +: CNT_W])
    );
  end
endmodule
